// File: rtl/switch_operand_loader.sv
// switch_operand_loader
//   Operand-entry front end for the 4-bit add/sub adder. Captures operand A,
//   then operand B and the mode bit from the slide switches on debounced
//   presses of the load button. Holds them stable and flags valid once both
//   operands are held. A debounced press of the clear button returns to the
//   empty state.
//
// Ports
//   clk       system clock; all state changes on its rising edge
//   rst_n     asynchronous active-low reset (internally released synchronously)
//   sw        raw operand switches (asynchronous)
//   sw_mode   raw mode switch, 0 = add, 1 = subtract (asynchronous)
//   btn_load  raw load pushbutton, active-high, bouncy
//   btn_clr   raw clear pushbutton, active-high, bouncy
//   op_a      held operand A
//   op_b      held operand B
//   op_m      held mode
//   valid     high while op_a, op_b and op_m are all captured
//   state     FSM state: 00 LOAD_A, 01 LOAD_B, 10 HOLD
module switch_operand_loader #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       sw_mode,
  input  logic       btn_load,
  input  logic       btn_clr,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic       op_m,
  output logic       valid,
  output logic [1:0] state
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    HOLD   = 2'b10,
    BAD    = 2'b11
  } state_e;

  // Reset synchronizer: assertion is immediate, release waits two edges.
  logic r_rst_meta, r_rst_sync;
  logic w_rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  assign w_rst_n = r_rst_sync;

  // Two-flop synchronizers, bit order {btn_clr, btn_load, sw_mode, sw[3:0]}.
  logic [6:0] r_in_meta, r_in_s;
  logic [3:0] w_sw_s;
  logic       w_mode_s;
  logic [1:0] w_btn_s;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_in_meta <= '0;
      r_in_s    <= '0;
    end else begin
      r_in_meta <= {btn_clr, btn_load, sw_mode, sw};
      r_in_s    <= r_in_meta;
    end
  end

  assign w_sw_s   = r_in_s[3:0];
  assign w_mode_s = r_in_s[4];
  assign w_btn_s  = r_in_s[6:5];

  // Debounce: index 0 = load, 1 = clear. The counter runs only while the
  // synchronized level disagrees with the accepted level; any agreement
  // restarts it, so a bounce shorter than DEBOUNCE_CYCLES never flips it.
  logic [CW-1:0] r_cnt [2];
  logic [1:0]    r_deb, r_deb_d;
  logic          w_load_pulse, w_clr_pulse;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int unsigned i = 0; i < 2; i++) r_cnt[i] <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
    end else begin
      r_deb_d <= r_deb;
      for (int unsigned i = 0; i < 2; i++) begin
        if (w_btn_s[i] != r_deb[i]) begin
          if (r_cnt[i] == CW'(DEBOUNCE_CYCLES)) begin
            r_deb[i] <= ~r_deb[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + CW'(1);
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_load_pulse = r_deb[0] & ~r_deb_d[0];
  assign w_clr_pulse  = r_deb[1] & ~r_deb_d[1];

  // FSM and held operands.
  state_e     r_state, w_state_nxt;
  logic [3:0] r_op_a, r_op_b, w_op_a_nxt, w_op_b_nxt;
  logic       r_op_m, r_valid, w_op_m_nxt, w_valid_nxt;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= LOAD_A;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_op_m  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_op_a  <= w_op_a_nxt;
      r_op_b  <= w_op_b_nxt;
      r_op_m  <= w_op_m_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_clr_pulse) begin
      w_state_nxt = LOAD_A;
    end else begin
      case (r_state)
        LOAD_A:  if (w_load_pulse) w_state_nxt = LOAD_B;
        LOAD_B:  if (w_load_pulse) w_state_nxt = HOLD;
        HOLD:    if (w_load_pulse) w_state_nxt = LOAD_B;
        default: w_state_nxt = LOAD_A;
      endcase
    end
  end

  always_comb begin
    w_op_a_nxt  = r_op_a;
    w_op_b_nxt  = r_op_b;
    w_op_m_nxt  = r_op_m;
    w_valid_nxt = r_valid;
    if (w_clr_pulse) begin
      w_op_a_nxt  = '0;
      w_op_b_nxt  = '0;
      w_op_m_nxt  = 1'b0;
      w_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        LOAD_A: if (w_load_pulse) w_op_a_nxt = w_sw_s;
        LOAD_B: if (w_load_pulse) begin
          w_op_b_nxt  = w_sw_s;
          w_op_m_nxt  = w_mode_s;
          w_valid_nxt = 1'b1;
        end
        // New entry: op_b/op_m stay until recaptured, only valid drops.
        HOLD: if (w_load_pulse) begin
          w_op_a_nxt  = w_sw_s;
          w_valid_nxt = 1'b0;
        end
        default: w_valid_nxt = 1'b0;
      endcase
    end
  end

  assign op_a  = r_op_a;
  assign op_b  = r_op_b;
  assign op_m  = r_op_m;
  assign valid = r_valid;
  assign state = r_state;

endmodule
